// File: rtl/count_seq_ctrl_if.sv
// Signal bundle between the run controller, board switch inputs and the 8-bit counter datapath.
// The controller uses the slave view; the board/counter side uses the master view.
interface count_seq_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             sw;
  logic             wrap_en;
  logic [WIDTH-1:0] count;
  logic             cnt_clr;
  logic             cnt_en;
  logic [1:0]       state;
  logic             done;

  modport master (
    output sw,
    output wrap_en,
    output count,
    input  cnt_clr,
    input  cnt_en,
    input  state,
    input  done
  );

  modport slave (
    input  sw,
    input  wrap_en,
    input  count,
    output cnt_clr,
    output cnt_en,
    output state,
    output done
  );
endinterface

// File: rtl/count_seq_ctrl.sv
// Run controller for a switch-enabled counter: debounces the run switch, sequences the counter
// through clear/run/hold/stop and issues prescaled one-cycle increment strobes.
module count_seq_ctrl #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DB_CYCLES = 4,
  parameter int unsigned      PRESC     = 5,
  parameter logic [WIDTH-1:0] TERM      = '1
) (
  input logic             clk,
  input logic             rst,
  count_seq_ctrl_if.slave bus
);

  localparam int unsigned    DbW    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int unsigned    PsW    = $clog2(PRESC);
  localparam logic [DbW-1:0] DbLast = DbW'(DB_CYCLES - 1);
  localparam logic [PsW-1:0] PsLast = PsW'(PRESC - 1);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StHold = 2'b10,
    StDone = 2'b11
  } state_e;

  state_e           state_q;
  logic             sync_q;
  logic             sw_s_q;
  logic             sw_db_q;
  logic             sw_db_prev_q;
  logic [DbW-1:0]   db_cnt_q;
  logic [PsW-1:0]   presc_q;
  logic             cnt_clr_q;
  logic             cnt_en_q;
  logic             done_q;
  logic             db_rise;
  logic             db_fall;

  // Synchronizer plus stability counter; sw_db only follows after DB_CYCLES mismatching samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q       <= 1'b0;
      sw_s_q       <= 1'b0;
      sw_db_q      <= 1'b0;
      sw_db_prev_q <= 1'b0;
      db_cnt_q     <= '0;
    end else begin
      sync_q       <= bus.sw;
      sw_s_q       <= sync_q;
      sw_db_prev_q <= sw_db_q;
      if (sw_s_q != sw_db_q) begin
        if (db_cnt_q == DbLast) begin
          sw_db_q  <= sw_s_q;
          db_cnt_q <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + DbW'(1);
        end
      end else begin
        db_cnt_q <= '0;
      end
    end
  end

  assign db_rise = sw_db_q & ~sw_db_prev_q;
  assign db_fall = ~sw_db_q & sw_db_prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      presc_q   <= '0;
      cnt_clr_q <= 1'b0;
      cnt_en_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cnt_clr_q <= 1'b0;
      cnt_en_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (db_rise) begin
            state_q   <= StRun;
            cnt_clr_q <= 1'b1;
            presc_q   <= '0;
          end
        end
        StRun: begin
          // A falling switch beats a coincident terminal tick; the prescaler stays frozen.
          if (db_fall) begin
            state_q <= StHold;
          end else if (presc_q == PsLast) begin
            presc_q <= '0;
            if (bus.count == TERM && !bus.wrap_en) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              cnt_en_q <= 1'b1;
            end
          end else begin
            presc_q <= presc_q + PsW'(1);
          end
        end
        StHold: begin
          if (db_rise) begin
            state_q <= StRun;
          end
        end
        StDone: begin
          if (db_fall) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
            presc_q <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.cnt_clr = cnt_clr_q;
  assign bus.cnt_en  = cnt_en_q;
  assign bus.state   = state_q;
  assign bus.done    = done_q;

endmodule
